skullfet_cell_tester: RTL and testbench
=======================================

# skullfet_cell_tester

Parametrised on-chip self-test harness for the SkullFET standard cells in the GF180 user project area. Drives each of `CHANNELS` cell-under-test instances (inverter or NAND) with an exhaustive 2-input vector sweep and waits a programmable settle time. It samples each cell output, compares it against the expected logic function, and accumulates per-channel pass/fail and a saturating error count. It sits inside `user_project_wrapper` between the Caravel I/O / logic-analyzer pins and the SkullFET cell instances.

## Interface
Parameters:
- `CHANNELS`, 4: number of cell-under-test channels (1..16).
- `CNT_W`, 16: width of `err_cnt` and `vec_cnt`.
- `SETTLE`, 2: wait cycles between drive and sample (>= 1).
- `LOOPS`, 1: full 4-vector sweeps per run (>= 1).

Ports:
- `wb_clk_i`  in  1  single clock, rising edge.
- `wb_rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  begin a run; honoured only in IDLE or DONE.
- `abort`  in  1  terminate a run; honoured in DRIVE/WAIT/SAMPLE.
- `mode`  in  CHANNELS  per-channel cell type: 0 = inverter, 1 = NAND. Must be stable during a run.
- `cell_a`  out  CHANNELS  A input to each cell.
- `cell_b`  out  CHANNELS  B input to each cell (don't-care for inverters, still driven).
- `cell_y`  in  CHANNELS  Y output from each cell.
- `busy`  out  1  run in progress.
- `done`  out  1  run completed normally; held until the next start.
- `pass`  out  1  valid when `done`; 1 if `fail_mask == 0`.
- `fail_mask`  out  CHANNELS  sticky per-channel mismatch flag.
- `err_cnt`  out  CNT_W  total mismatches, saturating.
- `vec_cnt`  out  CNT_W  vectors sampled this run, saturating.

## Operation
- States: IDLE, DRIVE, WAIT, SAMPLE, DONE.
- IDLE/DONE + `start`:
  - Clear `fail_mask`, `err_cnt`, `vec_cnt`, `done`, `pass`.
  - Set `busy`.
  - Load vector v = 0 and register `cell_a`/`cell_b` for all channels.
  - Go to DRIVE.
- Vector encoding: `cell_a = v[1]`, `cell_b = v[0]`, broadcast to all channels. Sweep order is 00, 01, 10, 11.
- DRIVE: one cycle, then WAIT.
- WAIT: lasts W cycles, then SAMPLE. W = `SETTLE`, or `SETTLE`+2 with the synchronizer enabled.
- SAMPLE: one cycle. Expected value is `~a` for inverter channels and `~(a&b)` for NAND channels.
  - `mismatch = expected ^ y_sampled`.
  - `fail_mask |= mismatch`.
  - `err_cnt += popcount(mismatch)`, saturating at 2^CNT_W-1.
  - `vec_cnt += 1`, saturating.
- SAMPLE exit:
  - If fewer than 4*LOOPS vectors have been sampled, v wraps mod 4, the next vector is registered on the same edge, and the FSM goes to DRIVE.
  - Otherwise go to DONE: `busy` = 0, `done` = 1, `pass` = ~|fail_mask, and `cell_a`/`cell_b` return to 0.
- `abort` in DRIVE/WAIT/SAMPLE:
  - Next state is IDLE.
  - `busy`, `done`, `pass`, `cell_a` and `cell_b` go to 0.
  - `fail_mask`, `err_cnt` and `vec_cnt` keep partial values.
  - No compare happens on the abort edge.
  - Abort wins over a simultaneous SAMPLE update.
- `start` during busy: ignored. `start` together with `abort`: abort wins.
- Reset, including mid-run: all outputs 0, state IDLE, synchronizer flops 0.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Each vector takes 2 + W cycles.
- `done` rises 4*LOOPS*(2+W) cycles after the edge on which `start` is sampled.
- `cell_y` must be stable at the sampled flop from DRIVE entry + W cycles onward.
- `err_cnt` and `vec_cnt` update on the SAMPLE exit edge.

## Configuration
- `SKULLFET_TESTER_SYNC_EN` defined:
  - `cell_y` passes through a 2-flop synchronizer per channel before compare.
  - W = `SETTLE`+2.
- Not defined:
  - `cell_y` is sampled directly into the compare register.
  - W = `SETTLE`.
  - Use only when the cells are characterised as settled within `SETTLE` cycles.

## Structure
- Package `skullfet_tester_pkg`:
  - FSM state enum.
  - Mode encoding constants (`MODE_INV`, `MODE_NAND`).
  - Expected-value function `exp_y(mode, a, b)`.
  - Vectors-per-sweep constant (4).
- Sub-module `skullfet_sync2`: 2-flop synchronizer with async active-low reset, instantiated per channel under the macro.

## Test plan
- CHANNELS=4, SETTLE=2, LOOPS=1, no sync, ideal cell models with mode=4'b0101. Pulse start → `done` exactly 16 cycles later, `pass`=1, `err_cnt`=0, `vec_cnt`=4.
- Same setup, channel 2 NAND stuck-at-0 → `fail_mask`=4'b0100, `err_cnt`=3 (vectors 00/01/10), `pass`=0.
- CNT_W=4, LOOPS=2, all four cells inverted-output → 32 mismatches, `err_cnt` saturates at 15, `vec_cnt`=8.
- Assert abort in WAIT of vector 2 → IDLE next cycle, `busy`=0, `done`=0, `cell_a`/`cell_b`=0, `vec_cnt`=2. A later start runs cleanly from counters cleared to 0.
- `wb_rst_n` low mid-run (and start pulsed while busy) → all outputs 0 immediately. While busy, start has no effect on the vector sequence.
- `SKULLFET_TESTER_SYNC_EN` defined, SETTLE=2, LOOPS=1 → `done` 24 cycles after start, `pass`=1 with ideal cells.

Source files
------------

// File: rtl/skullfet_tester_pkg.sv
// rtl/skullfet_tester_pkg.sv - shared types, mode encoding and expected-value function for the SkullFET cell tester
package skullfet_tester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    localparam logic MODE_INV  = 1'b0;
    localparam logic MODE_NAND = 1'b1;

    localparam int VEC_PER_SWEEP = 4;

    function automatic logic exp_y(input logic mode, input logic a, input logic b);
        return (mode == MODE_NAND) ? ~(a & b) : ~a;
    endfunction

endpackage

// File: rtl/skullfet_sync2.sv
// rtl/skullfet_sync2.sv - two-flop synchronizer for one cell output, async active-low reset
module skullfet_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/skullfet_cell_tester.sv
// rtl/skullfet_cell_tester.sv - exhaustive 2-input sweep tester for SkullFET cells; SKULLFET_TESTER_SYNC_EN adds a 2-flop input synchronizer
module skullfet_cell_tester
    import skullfet_tester_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int SETTLE   = 2,
    parameter int LOOPS    = 1
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [CHANNELS-1:0] mode,
    output logic [CHANNELS-1:0] cell_a,
    output logic [CHANNELS-1:0] cell_b,
    input  logic [CHANNELS-1:0] cell_y,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CHANNELS-1:0] fail_mask,
    output logic [CNT_W-1:0]    err_cnt,
    output logic [CNT_W-1:0]    vec_cnt
);

`ifdef SKULLFET_TESTER_SYNC_EN
    localparam int W = SETTLE + 2;
`else
    localparam int W = SETTLE;
`endif
    localparam int NVEC   = VEC_PER_SWEEP * LOOPS;
    localparam int WAIT_W = (W > 1) ? $clog2(W + 1) : 1;
    localparam int SMP_W  = $clog2(NVEC + 1);
    localparam int POP_W  = $clog2(CHANNELS + 1);
    localparam int SUM_W  = CNT_W + POP_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e               state_q;
    logic [WAIT_W-1:0]    wait_q;
    logic [SMP_W-1:0]     smp_q;
    logic [1:0]           v_q;
    logic                 busy_q, done_q, pass_q;
    logic [CHANNELS-1:0]  cell_a_q, cell_b_q, fail_mask_q;
    logic [CNT_W-1:0]     err_cnt_q, vec_cnt_q;

    logic [CHANNELS-1:0]  y_smp;

`ifdef SKULLFET_TESTER_SYNC_EN
    for (genvar i = 0; i < CHANNELS; i++) begin : g_sync
        skullfet_sync2 u_sync (
            .clk_i  (wb_clk_i),
            .rst_ni (wb_rst_n),
            .d_i    (cell_y[i]),
            .q_o    (y_smp[i])
        );
    end
`else
    logic [CHANNELS-1:0] y_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= cell_y;
        end
    end

    assign y_smp = y_q;
`endif

    logic [CHANNELS-1:0]  exp_vec, mismatch, fail_d;
    logic [POP_W-1:0]     pop;
    logic [SUM_W-1:0]     err_sum;
    logic [CNT_W-1:0]     err_d, vec_d;
    logic [1:0]           v_next;

    always_comb begin
        exp_vec = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            exp_vec[i] = exp_y(mode[i], cell_a_q[i], cell_b_q[i]);
        end
        mismatch = exp_vec ^ y_smp;
        pop = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pop = pop + POP_W'(mismatch[i]);
        end
        fail_d  = fail_mask_q | mismatch;
        err_sum = SUM_W'(err_cnt_q) + SUM_W'(pop);
        err_d   = (err_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : err_sum[CNT_W-1:0];
        vec_d   = (vec_cnt_q == CNT_MAX) ? vec_cnt_q : vec_cnt_q + CNT_W'(1);
        v_next  = v_q + 2'd1;
    end

    // Abort is checked ahead of the state case so it overrides a SAMPLE update on the same edge.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            smp_q       <= '0;
            v_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            cell_a_q    <= '0;
            cell_b_q    <= '0;
            fail_mask_q <= '0;
            err_cnt_q   <= '0;
            vec_cnt_q   <= '0;
        end else if (abort && (state_q == ST_DRIVE || state_q == ST_WAIT || state_q == ST_SAMPLE)) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            cell_a_q <= '0;
            cell_b_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start && !abort) begin
                        fail_mask_q <= '0;
                        err_cnt_q   <= '0;
                        vec_cnt_q   <= '0;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        v_q         <= 2'd0;
                        smp_q       <= '0;
                        cell_a_q    <= '0;
                        cell_b_q    <= '0;
                        state_q     <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    wait_q  <= WAIT_W'(W - 1);
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_q == '0) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        wait_q <= wait_q - WAIT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    fail_mask_q <= fail_d;
                    err_cnt_q   <= err_d;
                    vec_cnt_q   <= vec_d;
                    if (smp_q == SMP_W'(NVEC - 1)) begin
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        pass_q   <= ~|fail_d;
                        cell_a_q <= '0;
                        cell_b_q <= '0;
                    end else begin
                        smp_q    <= smp_q + SMP_W'(1);
                        v_q      <= v_next;
                        cell_a_q <= {CHANNELS{v_next[1]}};
                        cell_b_q <= {CHANNELS{v_next[0]}};
                        state_q  <= ST_DRIVE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cell_a    = cell_a_q;
    assign cell_b    = cell_b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = fail_mask_q;
    assign err_cnt   = err_cnt_q;
    assign vec_cnt   = vec_cnt_q;

endmodule

// File: tb/tb_skullfet_cell_tester.sv
// tb/tb_skullfet_cell_tester.sv - randomized self-checking bench for skullfet_cell_tester against a sweep-level reference model
module tb_skullfet_cell_tester;

    localparam int CH     = 4;
    localparam int SETTLE = 2;
    localparam int LOOPS  = 1;
`ifdef SKULLFET_TESTER_SYNC_EN
    localparam int W = SETTLE + 2;
`else
    localparam int W = SETTLE;
`endif
    localparam int VLEN   = 2 + W;
    localparam int RUNLEN = 4 * LOOPS * VLEN;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0, abort = 1'b0;
    logic [CH-1:0] mode = '0;
    logic [CH-1:0] cell_a, cell_b, cell_y, fail_mask;
    logic          busy, done, pass;
    logic [15:0]   err_cnt, vec_cnt;
    logic [1:0]    fault [CH];

    logic          start_s = 1'b0, abort_s = 1'b0;
    logic [3:0]    mode_s = 4'b0101;
    logic [3:0]    a_s, b_s, y_s, fm_s;
    logic          busy_s, done_s, pass_s;
    logic [3:0]    err_s, vec_s;

    int errors = 0;
    int checks = 0;

    skullfet_cell_tester #(.CHANNELS(CH), .CNT_W(16), .SETTLE(SETTLE), .LOOPS(LOOPS)) dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .cell_a(cell_a), .cell_b(cell_b), .cell_y(cell_y), .busy(busy), .done(done),
        .pass(pass), .fail_mask(fail_mask), .err_cnt(err_cnt), .vec_cnt(vec_cnt)
    );

    skullfet_cell_tester #(.CHANNELS(4), .CNT_W(4), .SETTLE(SETTLE), .LOOPS(2)) dut_sat (
        .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start_s), .abort(abort_s), .mode(mode_s),
        .cell_a(a_s), .cell_b(b_s), .cell_y(y_s), .busy(busy_s), .done(done_s),
        .pass(pass_s), .fail_mask(fm_s), .err_cnt(err_s), .vec_cnt(vec_s)
    );

    function automatic logic ideal(input logic m, input logic a, input logic b);
        return m ? !(a && b) : !a;
    endfunction

    // Cell models: 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 inverted output.
    always_comb begin
        cell_y = '0;
        for (int i = 0; i < CH; i++) begin
            case (fault[i])
                2'd0:    cell_y[i] = ideal(mode[i], cell_a[i], cell_b[i]);
                2'd1:    cell_y[i] = 1'b0;
                2'd2:    cell_y[i] = 1'b1;
                default: cell_y[i] = !ideal(mode[i], cell_a[i], cell_b[i]);
            endcase
        end
    end

    always_comb begin
        y_s = '0;
        for (int i = 0; i < 4; i++) y_s[i] = !ideal(mode_s[i], a_s[i], b_s[i]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected sticky mask and raw mismatch total after nv vectors of the sweep.
    task automatic model(input int nv, output logic [CH-1:0] m, output int e);
        logic a, b, id, act;
        m = '0;
        e = 0;
        for (int k = 0; k < nv; k++) begin
            a = ((k % 4) >= 2);
            b = ((k % 2) == 1);
            for (int i = 0; i < CH; i++) begin
                id = ideal(mode[i], a, b);
                case (fault[i])
                    2'd0:    act = id;
                    2'd1:    act = 1'b0;
                    2'd2:    act = 1'b1;
                    default: act = !id;
                endcase
                if (act != id) begin
                    m[i] = 1'b1;
                    e++;
                end
            end
        end
    endtask

    task automatic run(input int abort_at);
        int            c, e, nv;
        bit            ended;
        logic [CH-1:0] m;
        logic [1:0]    v;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        c = 0;
        ended = 0;
        while (!ended && c <= RUNLEN + 4) begin
            if (abort_at >= 0 && c == abort_at + 1) begin
                nv = abort_at / VLEN;
                model(nv, m, e);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_pass", pass, 0);
                check("abort_a", cell_a, 0);
                check("abort_b", cell_b, 0);
                check("abort_vec", vec_cnt, nv);
                check("abort_err", err_cnt, e);
                check("abort_mask", fail_mask, m);
                ended = 1;
            end else if (c < RUNLEN) begin
                v = 2'((c / VLEN) % 4);
                if (c == 0) begin
                    check("clr_vec", vec_cnt, 0);
                    check("clr_err", err_cnt, 0);
                    check("clr_mask", fail_mask, 0);
                end
                check("run_busy", busy, 1);
                check("run_done", done, 0);
                check("run_a", cell_a, {CH{v[1]}});
                check("run_b", cell_b, {CH{v[0]}});
            end else if (c == RUNLEN) begin
                model(4 * LOOPS, m, e);
                check("end_done", done, 1);
                check("end_busy", busy, 0);
                check("end_a", cell_a, 0);
                check("end_b", cell_b, 0);
                check("end_mask", fail_mask, m);
                check("end_err", err_cnt, (e > 65535) ? 65535 : e);
                check("end_vec", vec_cnt, 4 * LOOPS);
                check("end_pass", pass, (m == '0));
                ended = 1;
            end
            if (!ended) begin
                if (c == abort_at) begin
                    abort = 1'b1;
                    start = $urandom_range(0, 1) != 0;
                end else begin
                    abort = 1'b0;
                    start = ($urandom_range(0, 5) == 0);
                end
                @(negedge clk);
                c++;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        if (!ended) check("run_timeout", 0, 1);
        if (abort_at >= 0) begin
            @(negedge clk);
            check("abort_stay_idle", busy, 0);
        end
    endtask

    task automatic reset_mid_run();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat ($urandom_range(3, RUNLEN - 3)) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_a", cell_a, 0);
        check("rst_b", cell_b, 0);
        check("rst_mask", fail_mask, 0);
        check("rst_err", err_cnt, 0);
        check("rst_vec", vec_cnt, 0);
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic run_sat();
        int c;
        int e;
        @(negedge clk); start_s = 1'b1;
        @(negedge clk); start_s = 1'b0;
        c = 0;
        while (!done_s && c < 8 * VLEN + 8) begin
            @(negedge clk);
            c++;
        end
        e = 2 * 4 * 4;
        check("sat_latency", c, 8 * VLEN);
        check("sat_err", err_s, (e > 15) ? 15 : e);
        check("sat_vec", vec_s, 8);
        check("sat_mask", fm_s, 4'hF);
        check("sat_pass", pass_s, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < CH; i++) fault[i] = 2'd0;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_a", cell_a, 0);
        check("reset_err", err_cnt, 0);
        @(negedge clk); rst_n = 1'b1;

        mode = 4'b0101;
        run(-1);
        fault[2] = 2'd1;
        run(-1);
        check("stuck_err_direct", err_cnt, 3);
        check("stuck_mask_direct", fail_mask, 4'b0100);
        run_sat();

        run(2 * VLEN + 1);
        fault[2] = 2'd0;
        run(-1);
        reset_mid_run();
        run(-1);

        for (int r = 0; r < 24; r++) begin
            mode = CH'($urandom);
            for (int i = 0; i < CH; i++) fault[i] = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
            if ($urandom_range(0, 3) == 0) run(int'($urandom_range(0, RUNLEN - 1)));
            else run(-1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
